// File: rtl/serial_sub4.sv
// Bit-serial ripple subtractor: diff = a - b - bi, one bit per clock, LSB first.
// A single borrow flip-flop replaces the subtractor cell chain; result flagged by a one-cycle done.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full-subtractor borrow for one bit position.
    function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
        return (~x & y) | (~(x ^ y) & bin);
    endfunction

    state_t           state_r, state_s;
    logic [WIDTH-1:0] ra_r, ra_s;
    logic [WIDTH-1:0] rb_r, rb_s;
    logic             br_r, br_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [WIDTH-1:0] diff_r, diff_s;
    logic             bout_r, bout_s;
    logic             busy_r, done_r;
    logic             x_s, y_s, nb_s;

    // Next-state and datapath update for the serial subtraction.
    always_comb begin
        state_s = state_r;
        ra_s    = ra_r;
        rb_s    = rb_r;
        br_s    = br_r;
        idx_s   = idx_r;
        diff_s  = diff_r;
        bout_s  = bout_r;
        x_s     = ra_r[idx_r];
        y_s     = rb_r[idx_r];
        nb_s    = sub_borrow(x_s, y_s, br_r);

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    ra_s    = a;
                    rb_s    = b;
                    br_s    = bi;
                    idx_s   = {IW{1'b0}};
                    diff_s  = {WIDTH{1'b0}};
                    bout_s  = 1'b0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                diff_s[idx_r] = x_s ^ y_s ^ br_r;
                br_s          = nb_s;
                idx_s         = idx_r + {{(IW-1){1'b0}}, 1'b1};
                if (idx_r == LAST_IDX) begin
                    bout_s  = nb_s;
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ra_r    <= {WIDTH{1'b0}};
            rb_r    <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            idx_r   <= {IW{1'b0}};
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ra_r    <= ra_s;
            rb_r    <= rb_s;
            br_r    <= br_s;
            idx_r   <= idx_s;
            diff_r  <= diff_s;
            bout_r  <= bout_s;
            busy_r  <= (state_s == SHIFT);
            done_r  <= (state_s == DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_sub4.sv
// Directed bench for serial_sub4: table of subtractions plus hand-written
// sequences for ignored start, back-to-back operation and mid-operation reset.
module tb_serial_sub4;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bi;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         bout;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bi;
        logic [3:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    vec_t vecs[8];

    serial_sub4 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bi(bi),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called right after the accepting edge; returns edges elapsed until done and busy samples seen.
    task automatic wait_done(output int cyc, output int busy_cnt, output int overlap);
        cyc = 0;
        busy_cnt = 0;
        overlap = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            step();
            cyc++;
        end
        if (busy && done) overlap++;
    endtask

    task automatic run_op(input string name, input logic [3:0] va, input logic [3:0] vb,
                          input logic vbi, input logic [3:0] ed, input logic eb);
        int cyc, bc, ov;
        logic [3:0] held;
        a = va; b = vb; bi = vbi; start = 1'b1;
        step();
        start = 1'b0;
        a = ~va; b = ~vb; bi = ~vbi;
        wait_done(cyc, bc, ov);
        check({name, " done"}, int'(done), 1);
        check({name, " latency"}, cyc, W);
        check({name, " busy_cycles"}, bc, W);
        check({name, " overlap"}, ov, 0);
        check({name, " diff"}, int'(diff), int'(ed));
        check({name, " bout"}, int'(bout), int'(eb));
        held = diff;
        step();
        check({name, " done_pulse"}, int'(done), 0);
        check({name, " diff_hold"}, int'(diff), int'(ed));
        check({name, " hold_stable"}, int'(diff), int'(held));
    endtask

    initial begin
        int cyc, bc, ov, dcount;
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{4'd5,  4'd3,  1'b0, 4'd2,  1'b0};
        vecs[1] = '{4'd3,  4'd5,  1'b0, 4'd14, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
        vecs[3] = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0};
        vecs[4] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0};
        vecs[5] = '{4'd9,  4'd4,  1'b1, 4'd4,  1'b0};
        vecs[6] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1};
        vecs[7] = '{4'd8,  4'd8,  1'b1, 4'd15, 1'b1};

        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; bi = 1'b0;
        step();
        step();
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset diff", int'(diff), 0);
        check("reset bout", int'(bout), 0);

        // Reset overrides a simultaneous start.
        start = 1'b1; a = 4'd3; b = 4'd5;
        step();
        rst = 1'b0; start = 1'b0;
        check("rst_over_start busy", int'(busy), 0);
        step();
        check("rst_over_start idle", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bi,
                   vecs[i].exp_diff, vecs[i].exp_bout);
        end

        // Start pulsed during SHIFT is ignored.
        a = 4'd9; b = 4'd4; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 4'd1; b = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc, bc, ov);
        check("ign done", int'(done), 1);
        check("ign latency", cyc + 2, W);
        check("ign diff", int'(diff), 5);
        check("ign bout", int'(bout), 0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) dcount++;
        end
        check("ign no_second_done", dcount, 0);

        // Back-to-back with start held through DONE.
        a = 4'd7; b = 4'd1; bi = 1'b0; start = 1'b1;
        step();
        wait_done(cyc, bc, ov);
        check("b2b first done", int'(done), 1);
        check("b2b first latency", cyc, W);
        check("b2b first diff", int'(diff), 6);
        check("b2b first bout", int'(bout), 0);
        a = 4'd2; b = 4'd3;
        step();
        start = 1'b0;
        check("b2b restart busy", int'(busy), 1);
        check("b2b restart done", int'(done), 0);
        wait_done(cyc, bc, ov);
        check("b2b second done", int'(done), 1);
        check("b2b second gap", cyc + 1, W + 1);
        check("b2b second diff", int'(diff), 15);
        check("b2b second bout", int'(bout), 1);
        step();
        check("b2b end done", int'(done), 0);

        // Reset in the second SHIFT cycle aborts the operation.
        a = 4'd5; b = 4'd3; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort diff", int'(diff), 0);
        check("abort bout", int'(bout), 0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dcount++;
            step();
        end
        check("abort stays idle", dcount, 0);
        run_op("after_abort", 4'd8, 4'd8, 1'b0, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
